// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode constants, state encoding and decode helpers for the
// 4-stage pipeline control block.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned IR_W    = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 2;
  localparam int unsigned NREGS   = 4;
  localparam int unsigned NSTAGES = 4;

  // Full 4-bit opcodes
  localparam logic [OP_W-1:0] OP_LOAD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_STORE = 4'b0010;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0100;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
  localparam logic [OP_W-1:0] OP_NAND  = 4'b1000;
  localparam logic [OP_W-1:0] OP_BZ    = 4'b0101;
  localparam logic [OP_W-1:0] OP_BNZ   = 4'b1001;
  localparam logic [OP_W-1:0] OP_BPZ   = 4'b1101;
  localparam logic [OP_W-1:0] OP_NOP   = 4'b1010;
  localparam logic [OP_W-1:0] OP_STOP  = 4'b0001;

  // ORI and SHIFT are matched on the low three opcode bits only
  localparam logic [2:0] OP3_ORI   = 3'b111;
  localparam logic [2:0] OP3_SHIFT = 3'b011;

  // Fixed destination register of ORI
  localparam logic [REG_W-1:0] ORI_REG = 2'd1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Per-stage decode result
  typedef struct packed {
    logic             writer;
    logic [REG_W-1:0] dest;
    logic [NREGS-1:0] rd_mask;
  } dec_t;

  function automatic logic is_ori(input logic [OP_W-1:0] op);
    return (op[2:0] == OP3_ORI);
  endfunction

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op[2:0] == OP3_SHIFT);
  endfunction

  // Writes a register-file entry
  function automatic logic is_writer(input logic [OP_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_NAND) || is_ori(op) || is_shift(op);
  endfunction

  // Destination register of a writer
  function automatic logic [REG_W-1:0] dest_reg(input logic [OP_W-1:0]  op,
                                                input logic [REG_W-1:0] ra);
    return is_ori(op) ? ORI_REG : ra;
  endfunction

  function automatic logic reads_ra(input logic [OP_W-1:0] op);
    return (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_NAND) || is_shift(op);
  endfunction

  function automatic logic reads_rb(input logic [OP_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_NAND);
  endfunction

  function automatic logic reads_r1(input logic [OP_W-1:0] op);
    return is_ori(op);
  endfunction

  // Updates the N/Z flags in execute
  function automatic logic sets_flags(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
           is_ori(op) || is_shift(op);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of one instruction register: writer flag,
// destination register and one-hot mask of registers read.
module instr_decode
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output dec_t            dec
);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] ra;
  logic [REG_W-1:0] rb;

  assign op = ir[3:0];
  assign ra = ir[7:6];
  assign rb = ir[5:4];

  // Writer/destination and read-mask for this instruction
  always_comb begin
    dec        = '0;
    dec.writer = is_writer(op);
    dec.dest   = dest_reg(op, ra);
    if (reads_ra(op)) dec.rd_mask[ra]      = 1'b1;
    if (reads_rb(op)) dec.rd_mask[rb]      = 1'b1;
    if (reads_r1(op)) dec.rd_mask[ORI_REG] = 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Control for the 4-stage pipeline (IR1 fetch, IR2 read, IR3 execute,
// IR4 writeback): valid tracking, RAW stalls, branch flush and STOP halt.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [IR_W-1:0]    ir1,
  input  logic [IR_W-1:0]    ir2,
  input  logic [IR_W-1:0]    ir3,
  input  logic [IR_W-1:0]    ir4,
  input  logic               N,
  input  logic               Z,
  output logic               pc_write,
  output logic               pc_sel,
  output logic               ir1_load,
  output logic               ir2_load,
  output logic               ir3_load,
  output logic               ir4_load,
  output logic               r1r2_load,
  output logic               flag_write,
  output logic               alu_out_write,
  output logic               mem_write,
  output logic               mdr_load,
  output logic               rf_write,
  output logic               reg_in,
  output logic               stall,
  output logic               flush,
  output logic               halted,
  output logic [NSTAGES-1:0] stage_valid
);

  state_t             state_q, state_d;
  logic [NSTAGES-1:0] v_q, v_d;

  dec_t dec1, dec2, dec3, dec4;

  logic [OP_W-1:0]  op2, op3, op4;
  logic [NREGS-1:0] wmask3, wmask4;
  logic             hazard;
  logic             taken;
  logic             halt;

  // One decoder per pipeline stage
  instr_decode u_dec1 (.ir(ir1), .dec(dec1));
  instr_decode u_dec2 (.ir(ir2), .dec(dec2));
  instr_decode u_dec3 (.ir(ir3), .dec(dec3));
  instr_decode u_dec4 (.ir(ir4), .dec(dec4));

  // IR1 is not yet consumed by any stage; IR2 only reads, IR3/IR4 only write
  logic unused_dec;
  assign unused_dec = ^{dec1, dec2.writer, dec2.dest, dec3.rd_mask, dec4.rd_mask};

  assign op2  = ir2[3:0];
  assign op3  = ir3[3:0];
  assign op4  = ir4[3:0];
  assign halt = (state_q == ST_HALT);

  // RAW compare against both later stages, plus branch resolution in IR3
  always_comb begin
    wmask3 = '0;
    wmask4 = '0;
    if (v_q[2] && dec3.writer) wmask3[dec3.dest] = 1'b1;
    if (v_q[3] && dec4.writer) wmask4[dec4.dest] = 1'b1;
    // Register file is written at the end of the cycle, so IR4 must be checked
    hazard = v_q[1] && (|(dec2.rd_mask & (wmask3 | wmask4)));
    taken  = v_q[2] && (((op3 == OP_BZ)  &&  Z) ||
                        ((op3 == OP_BNZ) && !Z) ||
                        ((op3 == OP_BPZ) && !N));
  end

  // State and valid-bit register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
    end
  end

  // Next state, valid update and all strobes; everything is low during reset
  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    ir1_load      = 1'b0;
    ir2_load      = 1'b0;
    ir3_load      = 1'b0;
    ir4_load      = 1'b0;
    r1r2_load     = 1'b0;
    flag_write    = 1'b0;
    alu_out_write = 1'b0;
    mem_write     = 1'b0;
    mdr_load      = 1'b0;
    rf_write      = 1'b0;
    reg_in        = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    halted        = 1'b0;
    stage_valid   = '0;

    if (!reset) begin
      stall       = hazard;
      flush       = taken;
      halted      = halt;
      stage_valid = v_q;

      r1r2_load     = v_q[1] && !hazard;
      flag_write    = v_q[2] && sets_flags(op3);
      alu_out_write = v_q[2] && dec3.writer && (op3 != OP_LOAD);
      mem_write     = v_q[2] && (op3 == OP_STORE);
      mdr_load      = v_q[2] && (op3 == OP_LOAD);
      rf_write      = v_q[3] && dec4.writer;
      reg_in        = v_q[3] && (op4 == OP_LOAD);

      if (taken) begin
        // Branch retires from IR4 with no writes; two younger slots squashed
        pc_write = !halt;
        pc_sel   = 1'b0;
        ir1_load = !halt;
        ir2_load = 1'b1;
        ir3_load = 1'b1;
        ir4_load = 1'b1;
        v_d      = 4'b1000;
      end else if (hazard) begin
        // Hold IR1/IR2, insert a bubble into IR3
        ir3_load = 1'b1;
        ir4_load = 1'b1;
        v_d      = {v_q[2], 1'b0, v_q[1], v_q[0] && !halt};
      end else begin
        pc_write = !halt;
        pc_sel   = 1'b1;
        ir1_load = !halt;
        ir2_load = 1'b1;
        ir3_load = 1'b1;
        ir4_load = 1'b1;
        v_d      = {v_q[2], v_q[1], v_q[0], !halt};
      end

      // STOP in IR2 halts fetch unless squashed or held by a stall
      if (!halt && v_q[1] && (op2 == OP_STOP) && !taken && !hazard) begin
        state_d = ST_HALT;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a small datapath model feeds IR1..IR4 from a program
// memory; per-cycle expectations are queued and checked by a monitor.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ir1 = 8'h0A;
  logic [7:0] ir2 = 8'h0A;
  logic [7:0] ir3 = 8'h0A;
  logic [7:0] ir4 = 8'h0A;
  logic       N = 1'b0;
  logic       Z = 1'b0;

  logic pc_write, pc_sel, ir1_load, ir2_load, ir3_load, ir4_load;
  logic r1r2_load, flag_write, alu_out_write, mem_write, mdr_load;
  logic rf_write, reg_in, stall, flush, halted;
  logic [3:0] stage_valid;

  logic [7:0] pc        = 8'h00;
  logic [7:0] br_target = 8'd20;
  logic [7:0] imem [256];

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [19:0] mask;
    logic [19:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  localparam logic [19:0] PCW = 20'h80000;
  localparam logic [19:0] PCS = 20'h40000;
  localparam logic [19:0] L1  = 20'h20000;
  localparam logic [19:0] L2  = 20'h10000;
  localparam logic [19:0] L3  = 20'h08000;
  localparam logic [19:0] L4  = 20'h04000;
  localparam logic [19:0] R12 = 20'h02000;
  localparam logic [19:0] FW  = 20'h01000;
  localparam logic [19:0] AW  = 20'h00800;
  localparam logic [19:0] MW  = 20'h00400;
  localparam logic [19:0] MDR = 20'h00200;
  localparam logic [19:0] RFW = 20'h00100;
  localparam logic [19:0] RGI = 20'h00080;
  localparam logic [19:0] STL = 20'h00040;
  localparam logic [19:0] FLS = 20'h00020;
  localparam logic [19:0] HLT = 20'h00010;
  localparam logic [19:0] SV  = 20'h0000F;
  localparam logic [19:0] ALL = 20'hFFFFF;

  logic [19:0] obs;
  assign obs = {pc_write, pc_sel, ir1_load, ir2_load, ir3_load, ir4_load,
                r1r2_load, flag_write, alu_out_write, mem_write, mdr_load,
                rf_write, reg_in, stall, flush, halted, stage_valid};

  pipe_hazard_ctrl dut (
    .clock(clock), .reset(reset),
    .ir1(ir1), .ir2(ir2), .ir3(ir3), .ir4(ir4),
    .N(N), .Z(Z),
    .pc_write(pc_write), .pc_sel(pc_sel),
    .ir1_load(ir1_load), .ir2_load(ir2_load),
    .ir3_load(ir3_load), .ir4_load(ir4_load),
    .r1r2_load(r1r2_load), .flag_write(flag_write),
    .alu_out_write(alu_out_write), .mem_write(mem_write),
    .mdr_load(mdr_load), .rf_write(rf_write), .reg_in(reg_in),
    .stall(stall), .flush(flush), .halted(halted),
    .stage_valid(stage_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Datapath stand-in: PC and IR shift chain driven by the DUT enables
  always @(posedge clock) begin
    if (reset) pc <= 8'h00;
    else if (pc_write) pc <= pc_sel ? pc + 8'd1 : br_target;
    if (ir1_load) ir1 <= imem[pc];
    if (ir2_load) ir2 <= ir1;
    if (ir3_load) ir3 <= ir2;
    if (ir4_load) ir4 <= ir3;
  end

  // Monitor: pop every expectation due this cycle and compare
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (mon_e.cyc != cyc || (obs & mon_e.mask) !== mon_e.val) begin
        n_bad++;
        $display("FAIL %s (cycle +%0d): got %05h want %05h under mask %05h",
                 mon_e.name, mon_e.cyc, obs & mon_e.mask, mon_e.val, mon_e.mask);
      end
    end
  end

  task automatic exp_at(input int c, input logic [19:0] m,
                        input logic [19:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 8'h0A;
  endtask

  // One reset cycle; b is the first cycle after release
  task automatic start_test(output int b);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    b = cyc;
  endtask

  initial begin
    int b;
    wait_cycles(2);

    // RAW from IR3: ADD r0,r1 ; SUB r2,r0
    clear_mem(); imem[0] = 8'h14; imem[1] = 8'h86;
    start_test(b);
    exp_at(b,     PCW|L1|HLT|STL|RFW|SV, PCW|L1, "after_reset");
    exp_at(b + 3, STL|R12|PCW|L1|L2|L3|FW|SV, STL|L3|FW|20'h7, "raw3_stall1");
    exp_at(b + 4, STL|R12|RFW|FW|SV, STL|RFW|20'hB, "raw3_stall2");
    exp_at(b + 5, STL|R12|RFW|PCW|SV, R12|PCW|20'h3, "raw3_release");
    exp_at(b + 7, RFW|SV, RFW|20'hF, "raw3_sub_wb");
    wait_cycles(9);

    // RAW via ORI: ORI ; ADD r1,r2
    clear_mem(); imem[0] = 8'h07; imem[1] = 8'h64;
    start_test(b);
    exp_at(b + 3, STL|FW|AW|SV, STL|FW|AW|20'h7, "ori_stall1");
    exp_at(b + 4, STL|RFW|RGI|SV, STL|RFW|20'hB, "ori_stall2");
    exp_at(b + 5, STL|R12|SV, R12|20'h3, "ori_release");
    wait_cycles(7);

    // Independent: ADD r0,r1 ; SUB r2,r3
    clear_mem(); imem[0] = 8'h14; imem[1] = 8'hB6;
    start_test(b);
    exp_at(b + 3, STL|R12|RFW|SV, R12|20'h7, "indep_no_stall");
    exp_at(b + 4, STL|R12|RFW|SV, R12|RFW|20'hF, "indep_wb_add");
    exp_at(b + 5, STL|RFW|SV, RFW|20'hF, "indep_wb_sub");
    exp_at(b + 6, RFW, 20'h0, "indep_nop_wb");
    wait_cycles(8);

    // Branch taken: BZ with Z=1 ; ADD ; STORE squashed
    clear_mem(); imem[0] = 8'h05; imem[1] = 8'h14; imem[2] = 8'h02;
    Z = 1'b1;
    start_test(b);
    exp_at(b + 3, FLS|PCS|PCW|STL|MW|SV, FLS|PCW|20'h7, "bz_taken");
    exp_at(b + 4, FLS|RFW|MW|FW|AW|SV, 20'h8, "bz_squash1");
    exp_at(b + 5, RFW|MW|FW|AW|MDR|SV, 20'h1, "bz_squash2");
    exp_at(b + 6, RFW|MW|SV, 20'h3, "bz_refill");
    wait_cycles(8);

    // Branch not taken: BNZ with Z=1
    clear_mem(); imem[0] = 8'h09;
    Z = 1'b1;
    start_test(b);
    exp_at(b + 3, FLS|PCS|PCW|SV, PCS|PCW|20'h7, "bnz_not_taken");
    exp_at(b + 4, FLS|SV, 20'hF, "bnz_continue");
    wait_cycles(6);

    // BPZ with N=0 is taken
    clear_mem(); imem[0] = 8'h0D;
    N = 1'b0; Z = 1'b0;
    start_test(b);
    exp_at(b + 3, FLS|PCS|PCW, FLS|PCW, "bpz_taken");
    wait_cycles(5);

    // STOP after LOAD r1,r2
    clear_mem(); imem[0] = 8'h60; imem[1] = 8'h01;
    start_test(b);
    exp_at(b + 3, HLT|PCW|MDR|SV, PCW|MDR|20'h7, "stop_in_ir2");
    exp_at(b + 4, HLT|PCW|L1|RFW|RGI|SV, HLT|RFW|RGI|20'hF, "stop_halted");
    exp_at(b + 5, HLT|PCW|SV, HLT|20'hE, "stop_drain1");
    exp_at(b + 8, HLT|PCW|RFW|SV, HLT, "stop_drained");
    exp_at(b + 9, HLT|SV, HLT, "stop_stays");
    wait_cycles(11);

    // Reset mid-run with a full pipeline
    clear_mem();
    start_test(b);
    exp_at(b,     HLT|SV|PCW, PCW, "halt_cleared");
    exp_at(b + 4, HLT|SV, 20'hF, "full_pipe");
    exp_at(b + 5, ALL, 20'h0, "in_reset_all_zero");
    exp_at(b + 6, PCW|L1|R12|FW|AW|MW|MDR|RFW|RGI|STL|FLS|HLT|SV, PCW|L1,
           "post_reset");
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(2);

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Bound on total run time
  initial begin
    #20000;
    n_bad++;
    $display("FAIL watchdog: run did not complete, %0d expectations pending", sb.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Control block for the 4-stage pipelined datapath: Fetch into IR1, Register-read from IR2, Execute from IR3, Writeback from IR4. It sits upstream of the datapath registers and produces every stage load enable and gated write strobe. It tracks per-stage valid bits, stalls on read-after-write hazards, flushes on taken branches, and halts fetch on STOP.

## Interface

No parameters.

- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high
- ir1, ir2, ir3, ir4  in  8 each  contents of IR1..IR4 (opcode [3:0], ra [7:6], rb [5:4])
- N, Z  in  1 each  current flag register values
- pc_write  out  1  PC register enable
- pc_sel  out  1  PC source: 1 = PC+1, 0 = branch target from the ALU
- ir1_load, ir2_load, ir3_load, ir4_load  out  1 each  IR shift enables
- r1r2_load  out  1  R1/R2 capture enable (stage 2)
- flag_write, alu_out_write, mem_write, mdr_load  out  1 each  stage-3 strobes
- rf_write, reg_in  out  1 each  stage-4 write enable; reg_in = 1 selects MDR
- stall, flush, halted  out  1 each  status
- stage_valid  out  4  valid bits; bit k-1 = IRk

## Operation

**Opcodes** (match on [3:0] unless noted)
- LOAD 0000, STORE 0010, ADD 0100, SUB 0110, NAND 1000, BZ 0101, BNZ 1001, BPZ 1101, NOP 1010, STOP 0001
- ORI: [2:0] = 111. SHIFT: [2:0] = 011.

**Register writers and readers**
- Writers, dest ra: LOAD, ADD, SUB, NAND, SHIFT.
- Writer, dest fixed to register 1: ORI.
- Readers:
  - LOAD reads rb.
  - STORE, ADD, SUB, NAND read ra and rb.
  - SHIFT reads ra.
  - ORI reads register 1.
  - Branches, NOP and STOP read nothing.

**Hazard**
- stall = v2 & (IR2 reads a register that is the destination of a valid writer in IR3 or IR4).
- Register-file writes are not visible to the same-cycle read, so the IR4 check is required.

**Branch taken**
- Condition: v3 & (BZ & Z | BNZ & ~Z | BPZ & ~N).
- Drives flush = 1, pc_sel = 0, pc_write = 1.

**Stage strobes** (each gated by that stage's valid bit)
- r1r2_load = v2 & ~stall
- flag_write = v3 & (ADD | SUB | NAND | ORI | SHIFT)
- alu_out_write = v3 & (writer other than LOAD)
- mem_write = v3 & STORE
- mdr_load = v3 & LOAD
- rf_write = v4 & writer
- reg_in = v4 & LOAD

**State machine**: RUN and HALT.
- RUN → HALT when a valid STOP is in IR2 and there is no flush that cycle.
- HALT exits only by reset.
- In HALT: pc_write = 0, ir1_load = 0, v1 is cleared, and later stages keep draining. halted = 1.

**Valid update per edge** (priority: reset, then flush, then stall, then normal)
- reset: v = 0000, state RUN.
- flush: v4 ← 1 (the branch retires with no writes); v3, v2, v1 ← 0; PC ← target.
- stall: IR1, IR2, v1, v2 held (ir1_load = ir2_load = 0, pc_write = 0); v3 ← 0 (bubble); v4 ← v3; ir3_load = ir4_load = 1.
- normal: v4 ← v3, v3 ← v2, v2 ← v1, v1 ← ~HALT; all four IR loads = 1; pc_write = ~HALT; pc_sel = 1.

## Timing

- Outputs are combinational from the valid bits, the state and ir1..ir4. There are no output registers.
- While reset is high, every output is 0.
- After reset: stage_valid = 0000, halted = 0.
- The first fetch happens on the first edge after reset is released. That cycle drives pc_write = 1 and ir1_load = 1.
- Fill latency: an instruction's rf_write asserts 3 cycles after the cycle in which it was fetched.
- RAW stall length: 2 cycles if the producer is in IR3, 1 cycle if it is in IR4.
- Taken-branch penalty: 2 squashed instructions.
- Stall and flush in the same cycle: flush wins, because the stalled instruction is squashed.
- STOP in IR2 while stalled: the HALT transition waits until the stall clears.
- PC wrap-around is the datapath's concern; this block imposes no limit.

## Structure

- A shared package holds:
  - the opcode constants and the ORI/SHIFT 3-bit patterns
  - a state enum {RUN, HALT}
  - decode functions is_writer, dest_reg, reads_ra, reads_rb, reads_r1
- Sub-module `instr_decode` (combinational, instantiated once per stage) produces writer, dest and read-mask for one 8-bit instruction.
- The hazard compare, the valid pipeline and the FSM live in the top level.

## Test plan

- **Reset mid-run:** assert reset with stage_valid = 1111 → next edge stage_valid = 0000, halted = 0, all strobes 0.
- **RAW from IR3:** ADD r0,r1 then SUB r2,r0 → stall = 1 for 2 cycles, a bubble in IR3 each cycle, SUB gets r1r2_load = 1 only after ADD's rf_write.
- **RAW via ORI:** ORI followed by ADD r1,r2 → stall = 1 for 2 cycles.
- **Independent instructions:** ADD r0,r1; SUB r2,r3 → no stall, rf_write on consecutive cycles.
- **Branch taken:** BZ in IR3 with Z = 1 → flush = 1, pc_sel = 0, stage_valid becomes 1000; no rf_write or mem_write from the two squashed instructions.
- **Branch not taken:** BNZ with Z = 1 → flush = 0, pc_sel = 1.
- **STOP:** STOP after LOAD → halted = 1 the cycle after STOP reaches IR2, pc_write = 0 thereafter, LOAD still completes with rf_write = 1 and reg_in = 1, stage_valid drains to 0000.
